// File: rtl/bisr_output_writeback_pkg.sv
// Shared types and constants for the BISR output write-back buffer.
// Word width follows `MEM_PORT_WIDTH (32 when the macro is not supplied).
// Optional per-lane parity storage is controlled by WB_PARITY_EN.
`ifndef MEM_PORT_WIDTH
`define MEM_PORT_WIDTH 32
`endif

package bisr_wb_pkg;

    localparam int WB_CNT_W     = 16;
    localparam int WB_ADDR_W    = 32;
    localparam int WB_WORD_SIZE = 8;
    localparam int WB_MEM_W     = `MEM_PORT_WIDTH;
    localparam int WB_LANES     = WB_MEM_W / WB_WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } wb_state_t;

    // One queued memory beat; parity travels with the data when enabled.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_MEM_W-1:0]  data;
`ifdef WB_PARITY_EN
        logic [WB_LANES-1:0]  parity;
`endif
    } wb_entry_t;

    // Even parity of every WB_WORD_SIZE lane of a memory beat.
    function automatic logic [WB_LANES-1:0] lane_parity(input logic [WB_MEM_W-1:0] d);
        logic [WB_LANES-1:0] p;
        p = '0;
        for (int i = 0; i < WB_LANES; i++) begin
            p[i] = ^d[i*WB_WORD_SIZE +: WB_WORD_SIZE];
        end
        return p;
    endfunction

endpackage

// File: rtl/bisr_output_writeback_if.sv
// Memory write channel of the write-back buffer (valid/ready, address, data).
// No latency of its own; purely a bundle of wires.
// Beats are held stable by the master while m_valid && !m_ready (WB_PARITY_EN adds m_parity).
interface bisr_output_writeback_if
    import bisr_wb_pkg::*;
#(
    parameter int MEM_PORT_WIDTH = WB_MEM_W
);
    logic                      m_valid;
    logic                      m_ready;
    logic [WB_ADDR_W-1:0]      m_addr;
    logic [MEM_PORT_WIDTH-1:0] m_data;
`ifdef WB_PARITY_EN
    logic [WB_LANES-1:0]       m_parity;

    modport master (output m_valid, output m_addr, output m_data, output m_parity, input m_ready);
    modport slave  (input m_valid, input m_addr, input m_data, input m_parity, output m_ready);
`else
    modport master (output m_valid, output m_addr, output m_data, input m_ready);
    modport slave  (input m_valid, input m_addr, input m_data, output m_ready);
`endif
endinterface

// File: rtl/bisr_output_writeback_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and a registered-storage head output.
// A push is visible at the head on the following cycle; no same-cycle bypass.
// Push while full is only taken together with a pop; head reads zero when empty.
module bisr_wb_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] store [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign pop_ok  = pop && !empty;
    // When full, the slot being written is the one leaving through the head this cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : store[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue and discards any held beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are meaningless until covered by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bisr_output_writeback.sv
// Captures the output-RAM write stream, queues it and drains it to memory; pulses done per job.
// Latency: a beat pushed at edge N is offered on the memory channel right after edge N.
// Backpressure: stall (registered) rises when free entries <= STALL_MARGIN; WB_PARITY_EN adds lane parity.
module bisr_output_writeback
    import bisr_wb_pkg::*;
#(
    parameter int WORD_SIZE      = WB_WORD_SIZE,
    parameter int MEM_PORT_WIDTH = WB_MEM_W,
    parameter int DEPTH          = 8,
    parameter int STALL_MARGIN   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WB_CNT_W-1:0]       expected_words,
    input  logic                      wr_en,
    input  logic [WB_ADDR_W-1:0]      wr_addr,
    input  logic [MEM_PORT_WIDTH-1:0] wr_data,
    output logic                      stall,
    bisr_output_writeback_if.master   mem,
    output logic                      busy,
    output logic                      done,
    output logic                      err_overflow,
    output logic                      err_unexpected
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LANES = MEM_PORT_WIDTH / WORD_SIZE;

    wb_state_t           state;
    logic [WB_CNT_W-1:0] expected;
    logic [WB_CNT_W-1:0] push_cnt;
    logic [WB_CNT_W-1:0] pop_cnt;
    logic [WB_CNT_W-1:0] push_cnt_nxt;
    logic [WB_CNT_W-1:0] pop_cnt_nxt;

    wb_entry_t           push_entry;
    wb_entry_t           head_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic [AW:0]         fifo_count;
    logic [AW:0]         next_count;

    logic                room;
    logic                push;
    logic                pop;
    logic                drop;
    logic                stall_nxt;

    // Build the queued entry from the upstream write; parity is computed once, at push.
    always_comb begin
        push_entry      = '0;
        push_entry.addr = wr_addr;
        push_entry.data = wr_data;
`ifdef WB_PARITY_EN
        for (int i = 0; i < LANES; i++) begin
            push_entry.parity[i] = ^wr_data[i*WORD_SIZE +: WORD_SIZE];
        end
`endif
    end

    // A job accepts writes only while open and short of its word count.
    assign room  = (state == ACTIVE) && (push_cnt < expected);
    assign pop   = !fifo_empty && mem.m_ready;
    assign push  = wr_en && room && (!fifo_full || pop);
    assign drop  = wr_en && !push;

    assign push_cnt_nxt = push_cnt + WB_CNT_W'(push);
    assign pop_cnt_nxt  = pop_cnt + WB_CNT_W'(pop);
    assign next_count   = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    assign stall_nxt    = (((AW+1)'(DEPTH)) - next_count) <= (AW+1)'(STALL_MARGIN);

    bisr_wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .head  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign mem.m_valid  = !fifo_empty;
    assign mem.m_addr   = head_entry.addr;
    assign mem.m_data   = head_entry.data;
`ifdef WB_PARITY_EN
    assign mem.m_parity = head_entry.parity;
`endif

    assign busy = (state != IDLE);

    // Registered back-pressure, looking at the occupancy after this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall <= 1'b0;
        else      stall <= stall_nxt;
    end

    // Job FSM with word counters, done pulse and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            expected       <= '0;
            push_cnt       <= '0;
            pop_cnt        <= '0;
            done           <= 1'b0;
            err_overflow   <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) push_cnt <= push_cnt_nxt;
            if (pop)  pop_cnt  <= pop_cnt_nxt;

            // A write that the job wanted but could not store is an overflow;
            // anything else outside the job window is unexpected.
            if (drop) begin
                if (room && fifo_full) err_overflow   <= 1'b1;
                else                   err_unexpected <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        expected <= expected_words;
                        push_cnt <= '0;
                        pop_cnt  <= '0;
                        if (expected_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (push_cnt_nxt == expected) state <= DRAIN;
                end
                // Leave on the final handshake so done lands in the very next cycle.
                DRAIN: begin
                    if (pop_cnt_nxt == expected) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
